// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if: cache-side request bus and memory-side bus of the dmem write buffer
interface dmem_write_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   c_addr_i;
    logic [DATA_WIDTH-1:0]   c_wdata_i;
    logic                    c_write_i;
    logic [DATA_WIDTH/8-1:0] c_wstrb_i;
    logic                    c_read_i;
    logic [DATA_WIDTH-1:0]   c_rdata_o;
    logic                    c_ready_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_write_o;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_o;
    logic                    mem_read_o;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;
    logic                    mem_ready_i;
    modport slave (
        input  c_addr_i, c_wdata_i, c_write_i, c_wstrb_i, c_read_i, mem_rdata_i, mem_ready_i,
        output c_rdata_o, c_ready_o, mem_addr_o, mem_wdata_o, mem_write_o, mem_wstrb_o, mem_read_o
    );
    modport master (
        output c_addr_i, c_wdata_i, c_write_i, c_wstrb_i, c_read_i, mem_rdata_i, mem_ready_i,
        input  c_rdata_o, c_ready_o, mem_addr_o, mem_wdata_o, mem_write_o, mem_wstrb_o, mem_read_o
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted write FIFO with coalescing, read forwarding and in-order drain to data memory
module dmem_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic clk,
    input logic rst,
    dmem_write_buffer_if.slave bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int WW = ADDR_WIDTH - 2;
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, READ = 2'd2;

    logic [WW-1:0]         addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [SW-1:0]         strb_q [DEPTH];
    logic [PW-1:0]         head_q, tail_q, young, idx;
    logic [PW:0]           count_q;
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q, merged, hit_data;
    logic [SW-1:0]         mem_wstrb_q, hit_strb;
    logic                  mem_write_q, mem_read_q;
    logic [WW-1:0]         c_word;
    logic is_rd, coalesce, wr_acc, push, pop, hit, fwd, rd_issue, rd_done, head_merge, unused_ok;

    assign c_word     = bus.c_addr_i[ADDR_WIDTH-1:2];
    assign unused_ok  = ^bus.c_addr_i[1:0];
    assign young      = tail_q - 1'b1;
    assign is_rd      = bus.c_read_i && !bus.c_write_i;
    // the head is frozen once its contents have been presented to memory
    assign coalesce   = bus.c_write_i && count_q != '0 && addr_q[young] == c_word &&
                        !(state_q == DRAIN && young == head_q);
    assign wr_acc     = !rst && bus.c_write_i && (coalesce || count_q < (PW+1)'(DEPTH));
    assign push       = wr_acc && !coalesce;
    assign pop        = state_q == DRAIN && bus.mem_ready_i;
    assign head_merge = wr_acc && coalesce && young == head_q;
    assign fwd        = is_rd && state_q != READ && hit && &hit_strb;
    assign rd_issue   = is_rd && state_q == IDLE && !hit;
    assign rd_done    = state_q == READ && bus.mem_ready_i;
    assign state_d    = state_q == IDLE ? (rd_issue ? READ : count_q != '0 ? DRAIN : IDLE) :
                        bus.mem_ready_i ? IDLE : state_q;

    always_comb begin
        merged = data_q[young];
        for (int b = 0; b < SW; b++)
            if (bus.c_wstrb_i[b]) merged[8*b +: 8] = bus.c_wdata_i[8*b +: 8];
    end

    // oldest-to-youngest scan so the last match is the youngest entry for that word
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_strb = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (i < int'(count_q) && addr_q[idx] == c_word) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
                hit_strb = strb_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= c_word;
            data_q[tail_q] <= bus.c_wdata_i;
            strb_q[tail_q] <= bus.c_wstrb_i;
        end
        if (wr_acc && coalesce) begin
            data_q[young] <= merged;
            strb_q[young] <= strb_q[young] | bus.c_wstrb_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(push);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (state_q == IDLE && state_d == READ) begin
                mem_read_q <= 1'b1;
                mem_addr_q <= {c_word, 2'b00};
            end else if (state_q == IDLE && state_d == DRAIN) begin
                // a write merging into the head this cycle must reach memory too
                mem_write_q <= 1'b1;
                mem_addr_q  <= {addr_q[head_q], 2'b00};
                mem_wdata_q <= head_merge ? merged : data_q[head_q];
                mem_wstrb_q <= head_merge ? strb_q[head_q] | bus.c_wstrb_i : strb_q[head_q];
            end else if (state_q != IDLE && bus.mem_ready_i) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    assign bus.c_ready_o   = !rst && (wr_acc || fwd || rd_done);
    assign bus.c_rdata_o   = rst ? '0 : fwd ? hit_data : rd_done ? bus.mem_rdata_i : '0;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;
    assign bus.mem_write_o = mem_write_q;
    assign bus.mem_read_o  = mem_read_q;
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed scenarios plus random traffic checked against a logical-memory model
module tb_dmem_write_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_err = 0, rdy_mode = 0, rd_seen = 0;
    logic [31:0] mem_m [int unsigned];
    logic [31:0] sh_m [int unsigned];
    logic        ev_wr [$];
    logic [31:0] ev_addr [$];
    logic [31:0] ev_data [$];
    logic [3:0]  ev_strb [$];

    dmem_write_buffer_if bus ();
    dmem_write_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input int unsigned w);
        return w * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mget(input int unsigned w);
        return mem_m.exists(w) ? mem_m[w] : dflt(w);
    endfunction

    function automatic logic [31:0] sget(input int unsigned w);
        return sh_m.exists(w) ? sh_m[w] : dflt(w);
    endfunction

    // memory model: a transfer completes in any cycle where ready is driven with a request present
    always @(negedge clk) begin
        bus.mem_ready_i = !rst && (rdy_mode == 1 || (rdy_mode == 2 && $urandom_range(0, 1) == 1));
        bus.mem_rdata_i = bus.mem_read_o ? mget(bus.mem_addr_o >> 2) : $urandom();
        if (!rst && bus.mem_read_o) rd_seen++;
        if (bus.mem_ready_i && (bus.mem_write_o || bus.mem_read_o)) begin
            if (bus.mem_write_o)
                mem_m[bus.mem_addr_o >> 2] = merge(mget(bus.mem_addr_o >> 2), bus.mem_wdata_o, bus.mem_wstrb_o);
            ev_wr.push_back(bus.mem_write_o);
            ev_addr.push_back(bus.mem_addr_o);
            ev_data.push_back(bus.mem_wdata_o);
            ev_strb.push_back(bus.mem_wstrb_o);
        end
    end

    task automatic clear_ev();
        ev_wr.delete();
        ev_addr.delete();
        ev_data.delete();
        ev_strb.delete();
    endtask

    task automatic cwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        bus.c_addr_i  = a;
        bus.c_wdata_i = d;
        bus.c_wstrb_i = s;
        bus.c_write_i = 1'b1;
        lat = -1;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            #2;
            if (bus.c_ready_o) lat = i;
            @(negedge clk);
        end
        bus.c_write_i = 1'b0;
        if (lat >= 0) sh_m[a >> 2] = merge(sget(a >> 2), d, s);
        chk("wr_done", lat >= 0, 1);
    endtask

    task automatic cread(input logic [31:0] a, output int lat, output logic [31:0] rd);
        bus.c_addr_i = a;
        bus.c_read_i = 1'b1;
        lat = -1;
        rd  = '0;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            #2;
            if (bus.c_ready_o) begin
                lat = i;
                rd  = bus.c_rdata_o;
            end
            @(negedge clk);
        end
        bus.c_read_i = 1'b0;
        chk("rd_done", lat >= 0, 1);
        chk("rd_data", rd, sget(a >> 2));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 500 && (dut.count_q != 0 || bus.mem_write_o || bus.mem_read_o)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 500, 1);
    endtask

    initial begin
        int lat, n;
        logic [31:0] rd, a;
        bus.c_addr_i  = '0;
        bus.c_wdata_i = '0;
        bus.c_wstrb_i = '0;
        bus.c_write_i = 1'b0;
        bus.c_read_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.c_ready_o, 0);
        chk("rst_rdata", bus.c_rdata_o, 0);
        chk("rst_mem_ctl", {bus.mem_write_o, bus.mem_read_o, bus.mem_addr_o, bus.mem_wstrb_o}, 0);
        chk("rst_wdata", bus.mem_wdata_o, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_count", dut.count_q, 0);

        rdy_mode = 1;
        cwrite(32'h100, 32'hDEADBEEF, 4'hF, lat);
        chk("t1_accept_lat", lat, 0);
        n = 1;
        while (!bus.mem_write_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t1_wr_lat", n <= 2, 1);
        chk("t1_addr", bus.mem_addr_o, 32'h100);
        chk("t1_data", bus.mem_wdata_o, 32'hDEADBEEF);
        chk("t1_strb", bus.mem_wstrb_o, 4'hF);
        wait_idle("t1_idle");
        chk("t1_count", dut.count_q, 0);

        rdy_mode = 0;
        clear_ev();
        for (int k = 0; k < 4; k++) begin
            cwrite(32'h1000 + 32'(k * 16), 32'hA0 + 32'(k), 4'hF, lat);
            chk("t2_accept", lat, 0);
        end
        fork
            cwrite(32'h1040, 32'hA4, 4'hF, lat);
            begin
                repeat (6) @(negedge clk);
                rdy_mode = 1;
            end
        join
        chk("t2_full_stall", lat >= 6, 1);
        wait_idle("t2_idle");
        chk("t2_nwr", ev_addr.size(), 5);
        for (int k = 0; k < 5 && k < ev_addr.size(); k++) begin
            chk("t2_is_wr", ev_wr[k], 1);
            chk("t2_order", ev_addr[k], 32'h1000 + 32'(k * 16));
        end

        rdy_mode = 0;
        clear_ev();
        cwrite(32'h200, 32'h0000AAAA, 4'h3, lat);
        cwrite(32'h200, 32'hBBBB0000, 4'hC, lat);
        chk("t3_merge_lat", lat, 0);
        rdy_mode = 1;
        wait_idle("t3_idle");
        chk("t3_nwr", ev_addr.size(), 1);
        if (ev_addr.size() == 1) begin
            chk("t3_data", ev_data[0], 32'hBBBBAAAA);
            chk("t3_strb", ev_strb[0], 4'hF);
        end

        rdy_mode = 0;
        clear_ev();
        n = rd_seen;
        cwrite(32'h300, 32'h12345678, 4'hF, lat);
        cread(32'h300, lat, rd);
        chk("t4_fwd_lat", lat, 0);
        chk("t4_fwd_data", rd, 32'h12345678);
        rdy_mode = 1;
        wait_idle("t4_idle");
        chk("t4_no_mem_read", rd_seen - n, 0);

        rdy_mode = 0;
        clear_ev();
        mem_m[32'h100] = 32'h0;
        sh_m[32'h100]  = 32'h0;
        cwrite(32'h400, 32'h00000055, 4'h1, lat);
        fork
            cread(32'h400, lat, rd);
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 1;
            end
        join
        chk("t5_stall", lat >= 4, 1);
        chk("t5_data", rd, 32'h55);
        chk("t5_nev", ev_addr.size(), 2);
        if (ev_addr.size() == 2) begin
            chk("t5_first_wr", ev_wr[0], 1);
            chk("t5_then_rd", ev_wr[1], 0);
            chk("t5_rd_addr", ev_addr[1], 32'h400);
        end

        rdy_mode = 0;
        clear_ev();
        cwrite(32'h500, 32'hCAFEF00D, 4'hF, lat);
        bus.c_addr_i = 32'h602;
        bus.c_read_i = 1'b1;
        @(negedge clk);
        chk("t6_rd_issued", bus.mem_read_o, 1);
        chk("t6_no_wr", bus.mem_write_o, 0);
        chk("t6_rd_addr", bus.mem_addr_o, 32'h600);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_rd", bus.mem_read_o, 0);
        chk("t6_rst_ready", bus.c_ready_o, 0);
        chk("t6_rst_count", dut.count_q, 0);
        bus.c_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sh_m[32'h140] = mget(32'h140);

        rdy_mode = 2;
        for (int k = 0; k < 200; k++) begin
            a = 32'h800 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 6) cwrite(a, $urandom(), 4'($urandom_range(1, 15)), lat);
            else cread(a, lat, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 1;
        wait_idle("rand_idle");
        for (int w = 0; w < 6; w++) chk("rand_mem", mget(32'h200 + w), sget(32'h200 + w));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted write buffer between the data cache's dmem_* master port and the data memory.
- Absorbs cache write-backs without stalling the cache, drains them to memory in order, and services cache line-fill reads.
- Read-after-write ordering is kept by forwarding, stalling or bypassing.
- One outstanding memory transaction at a time.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width (multiple of 8)
DEPTH, 4, buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
c_addr_i  input  ADDR_WIDTH  cache request byte address
c_wdata_i  input  DATA_WIDTH  cache write data
c_write_i  input  1  cache write request, held until c_ready_o
c_wstrb_i  input  DATA_WIDTH/8  byte enables for write
c_read_i  input  1  cache read request, held until c_ready_o
c_rdata_o  output  DATA_WIDTH  read data, valid when c_ready_o && c_read_i
c_ready_o  output  1  request completes this cycle (combinational)
mem_addr_o  output  ADDR_WIDTH  memory address (registered)
mem_wdata_o  output  DATA_WIDTH  memory write data (registered)
mem_write_o  output  1  memory write request (registered)
mem_wstrb_o  output  DATA_WIDTH/8  memory byte enables (registered)
mem_read_o  output  1  memory read request (registered)
mem_rdata_i  input  DATA_WIDTH  memory read data
mem_ready_i  input  1  memory transfer completes this cycle

Behaviour:
- Storage: circular FIFO of {word addr = addr[ADDR_WIDTH-1:2], data, strb}, plus head/tail pointers and count (0..DEPTH).
- Reset: count=0, pointers=0, state IDLE, all mem_* outputs 0, c_ready_o=0, c_rdata_o=0. Reset asserted mid-transaction abandons it; outputs drop immediately.
- Write accept: when c_write_i && count<DEPTH, c_ready_o=1 the same cycle and the entry is pushed at the clock edge.
- Write coalescing: if count>0, the youngest entry matches the word address, and that entry is not the head currently in DRAIN, merge into it instead of pushing.
  - Merge: bytes with strb=1 are overwritten; strb |= c_wstrb_i; count unchanged.
  - Coalescing is permitted while full.
- Full: count==DEPTH with no coalesce means c_ready_o=0. A pop in the same cycle does not free the slot until the next cycle.
- c_read_i && c_write_i both high: illegal. The block treats the request as a write.
- Read classification (evaluated when state != READ), using the youngest matching entry:
  - Forward: match with strb all ones. c_rdata_o=entry data, c_ready_o=1 same cycle, no memory access.
  - Partial: any match without full strobe. Stall (c_ready_o=0) until count==0, then treat as no match.
  - No match: issue to memory when state is IDLE, with priority over drain.
- FSM states IDLE, DRAIN, READ:
  - IDLE -> READ: no-match read pending. Next cycle mem_read_o=1, mem_addr_o=c_addr_i word-aligned (low 2 bits 0), mem_write_o=0.
  - IDLE -> DRAIN: count>0 and no issuable read. Next cycle mem_write_o=1 with the head's addr<<2, data and strb.
  - DRAIN -> IDLE: on mem_ready_i. Pop head, deassert mem_write_o next cycle. There is one idle cycle between back-to-back drains.
  - READ -> IDLE: on mem_ready_i. c_rdata_o=mem_rdata_i, c_ready_o=1 the same cycle; mem_read_o deasserts next cycle.
- Requests are held stable while mem_ready_i=0.
- Read arriving during DRAIN: waits for drain completion, then takes priority in IDLE.
- Write accept and pop in the same cycle are both legal; count is net unchanged.
- Latency: a buffered write reaches memory no earlier than 1 cycle after acceptance; a no-match read reaches memory 1 cycle after request in IDLE.

Test Plan:
- Reset, then write addr 0x100, data 0xDEADBEEF, strb 0xF with mem_ready_i=1 -> c_ready_o=1 same cycle; next cycle mem_write_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF; count returns to 0.
- Hold mem_ready_i=0 and issue 5 writes to distinct addresses, DEPTH=4 -> first 4 accepted, 5th sees c_ready_o=0. Raise mem_ready_i -> memory sees writes in order, 5th accepted after first pop.
- With mem_ready_i=0, write 0x200 strb 0x3 data 0x0000AAAA, then 0x200 strb 0xC data 0xBBBB0000 -> single entry; drain shows data 0xBBBBAAAA, strb 0xF.
- Buffer 0x300 = 0x12345678 (strb 0xF), read 0x300 -> c_ready_o=1 same cycle, c_rdata_o=0x12345678, mem_read_o never asserted.
- Buffer 0x400 with strb 0x1, read 0x400 -> stall until buffer empty, then mem_read_o=1 at 0x400; memory returns 0x55 -> c_rdata_o=0x55.
- Buffer 0x500, read 0x600 while IDLE -> mem_read_o precedes the drain write. Assert rst during the read -> mem_read_o=0 immediately and count=0.
